// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide unit: FSM state encodings,
// result-ready flag values and the default operand width.
package div_ctrl_pkg;

    localparam int DivDataW = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the divide
// controller (slave).
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DivDataW
) ();

    logic                  start;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  annul;
    logic                  advance;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;
    logic                  stallreq;

    modport master (
        output start, signed_div, opdata1, opdata2, annul, advance,
        input  result, ready, stallreq
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul, advance,
        output result, ready, stallreq
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on the {remainder, quotient} register:
// shift left, trial-subtract the divisor from the upper half, keep if no borrow.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] work_o
);

    logic [DATA_W:0] minuend;
    logic [DATA_W:0] diff;

    // The upper half after the shift needs DATA_W+1 bits; since the partial
    // remainder stays below the divisor, bit DATA_W of the difference is the borrow.
    assign minuend = work_i[2*DATA_W-1:DATA_W-1];
    assign diff    = minuend - {1'b0, divisor_i};

    always_comb begin
        work_o = {work_i[2*DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            work_o = {diff[DATA_W-1:0], work_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle div/divu unit.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in two cycles with result 0.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DivDataW
) (
    input  logic          clk,
    input  logic          rst,
    div_ctrl_if.slave     bus
);

    localparam int CntW = $clog2(DATA_W) + 1;

    div_state_e            state_q, state_d;
    logic [2*DATA_W-1:0]   work_q, work_d, work_step;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic en);
        return en ? DATA_W'(~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        return cond_neg(v, is_signed & v[DATA_W-1]);
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;

        // A flush abandons the operation without touching the held result.
        if (bus.annul) begin
            state_d = DivFree;
        end else begin
            case (state_q)
                DivFree: begin
                    if (bus.start) begin
                        divisor_d = magnitude(bus.opdata2, bus.signed_div);
                        work_d    = {{DATA_W{1'b0}}, magnitude(bus.opdata1, bus.signed_div)};
                        qneg_d    = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                        rneg_d    = bus.signed_div & bus.opdata1[DATA_W-1];
                        cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
                        state_d   = (bus.opdata2 == '0) ? DivByZero : DivOn;
`else
                        state_d   = DivOn;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DivByZero: begin
                    result_d = '0;
                    state_d  = DivEnd;
                end
`endif
                DivOn: begin
                    work_d = work_step;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        result_d = {cond_neg(work_step[2*DATA_W-1:DATA_W], rneg_q),
                                    cond_neg(work_step[DATA_W-1:0], qneg_q)};
                        state_d  = DivEnd;
                    end
                end
                DivEnd: begin
                    if (bus.advance) begin
                        state_d = DivFree;
                    end
                end
                default: state_d = DivFree;
            endcase
        end

        ready_d = (state_d == DivEnd) ? DivResultReady : DivResultNotReady;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            work_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.ready    = ready_q;
    assign bus.stallreq = rst & bus.start & ~bus.annul & (state_q != DivEnd);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    div_ctrl_if #(.DATA_W(W)) bus ();

    div_ctrl #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'h0;
`else
            // Magnitude iteration yields all-ones quotient and |a| remainder;
            // the sign fix then depends only on the dividend sign.
            if (!s) return {a, 32'hFFFF_FFFF};
            return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
        end
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 2;
`endif
        return W + 1;
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold);
        logic [63:0] exp;
        int lat;
        int cyc;
        exp = ref_div(a, b, s);
        lat = ref_lat(b);
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = s; bus.opdata1 = a; bus.opdata2 = b;
        bus.annul = 1'b0; bus.advance = 1'b0;
        #1;
        check("stall_c0", 64'(bus.stallreq), 64'd1);
        check("ready_c0", 64'(bus.ready), 64'd0);
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ready !== 1'b1) check("stall_busy", 64'(bus.stallreq), 64'd1);
            bus.opdata1 = $urandom; bus.opdata2 = $urandom; bus.signed_div = 1'($urandom);
        end
        check("latency", 64'(cyc), 64'(lat));
        check("result", bus.result, exp);
        check("stall_end", 64'(bus.stallreq), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_ready", 64'(bus.ready), 64'd1);
            check("hold_result", bus.result, exp);
        end
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0; bus.start = 1'b0;
        check("ready_idle", 64'(bus.ready), 64'd0);
        last_res = exp;
    endtask

    initial begin
        logic seen;
        logic [31:0] a, b;
        logic s;

        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
        bus.annul = 1'b0; bus.advance = 1'b0;
        #12;
        check("rst_stall", 64'(bus.stallreq), 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_result", bus.result, 64'd0);
        bus.start = 1'b0;
        @(negedge clk); rst = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 5);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        run_div(32'd5, 32'd0, 1'b0, 1);
        run_div(32'hFFFF_FFF6, 32'd0, 1'b1, 0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0);
        run_div(32'd7, 32'hFFFF_FFFD, 1'b1, 0);

        // Flush in cycle 10 of an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
        repeat (10) @(posedge clk);
        #1 bus.annul = 1'b1;
        #1 check("annul_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk); #1;
        bus.annul = 1'b0; bus.start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.ready;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_result_kept", bus.result, last_res);
        check("annul_stall_drop", 64'(bus.stallreq), 64'd0);

        // Reset in cycle 20 of an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b1; bus.opdata1 = 32'hFFFF_0000; bus.opdata2 = 32'd5;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_ready", 64'(bus.ready), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk); #1;
        check("midrst_hold_result", bus.result, 64'd0);
        bus.start = 1'b0;
        @(negedge clk); rst = 1'b1;

        run_div(32'd12345, 32'd67, 1'b0, 2);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = (i % 2 == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
                default: b = -32'($urandom_range(1, 9));
            endcase
            s = 1'($urandom);
            run_div(a, b, s, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
